// File: rtl/oneshot_multi_pkg.sv
// Shared types and constants for the multi-channel one-shot generator.
//   os_state_t      : per-channel FSM state (idle / active pulse / post-pulse holdoff)
//   OS_SYNC_STAGES  : depth of the optional trigger synchroniser
//   hold_cnt_width  : width of the holdoff counter for a given HOLDOFF, never below 1
package oneshot_multi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHoldoff
  } os_state_t;

  localparam int unsigned OS_SYNC_STAGES = 2;

  function automatic int unsigned hold_cnt_width(input int unsigned holdoff);
    return (holdoff == 0) ? 1 : $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/oneshot_chan.sv
// One channel of the one-shot generator: optional trigger synchroniser, rising-edge
// detect, IDLE/ACTIVE/HOLDOFF FSM, pulse-length and holdoff counters.
// Build option: ONESHOT_MULTI_SYNC_EN adds a 2-flop synchroniser (reset to 1) on trig_in.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   global enable for new triggers
//   trig_in    in   trigger level
//   len        in   pulse length (0 is treated as 1), sampled at load/reload only
//   retrig     in   1 = retriggerable while ACTIVE
//   pulse_out  out  registered pulse
//   busy       out  registered, high in ACTIVE or HOLDOFF
//   done       out  registered strobe in the first cycle after the pulse
module oneshot_chan
  import oneshot_multi_pkg::*;
#(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             trig_in,
  input  logic [LEN_W-1:0] len,
  input  logic             retrig,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned HoldW = hold_cnt_width(HOLDOFF);

  logic trig_s;

`ifdef ONESHOT_MULTI_SYNC_EN
  logic [OS_SYNC_STAGES-1:0] sync_q;

  // Reset to 1 so a trigger already high at reset release does not look like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[OS_SYNC_STAGES-2:0], trig_in};
    end
  end

  assign trig_s = sync_q[OS_SYNC_STAGES-1];
`else
  assign trig_s = trig_in;
`endif

  os_state_t              state_q, state_d;
  logic       [LEN_W-1:0] cnt_q, cnt_d;
  logic       [HoldW-1:0] hcnt_q, hcnt_d;
  logic                   prev_q;
  logic                   pulse_q, pulse_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fire;
  logic       [LEN_W-1:0] eff_len;

  // prev updates every cycle, so edges seen in ACTIVE (non-retrig) or HOLDOFF are consumed.
  assign fire    = trig_s & ~prev_q & en;
  assign eff_len = (len == '0) ? LEN_W'(1) : len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          cnt_d   = eff_len;
          state_d = StActive;
        end
      end
      StActive: begin
        // A retrigger wins over expiry in the same cycle.
        if (fire && retrig) begin
          cnt_d = eff_len;
        end else if (cnt_q == LEN_W'(1)) begin
          cnt_d  = '0;
          done_d = 1'b1;
          if (HOLDOFF > 0) begin
            state_d = StHoldoff;
            hcnt_d  = HoldW'(HOLDOFF);
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      StHoldoff: begin
        if (hcnt_q == HoldW'(1)) begin
          hcnt_d  = '0;
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q - HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    pulse_d = (state_d == StActive);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      prev_q  <= trig_s;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: rtl/oneshot_multi.sv
// Multi-channel one-shot pulse generator: CH independent channels, each with a
// run-time pulse length, optional retrigger and a fixed post-pulse holdoff.
// Build option: ONESHOT_MULTI_SYNC_EN (see oneshot_chan) adds 2 cycles of trigger latency.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   global enable; running pulses complete when low
//   trig_in    in   [CH] trigger levels
//   len        in   [CH*LEN_W] pulse lengths, channel i at [i*LEN_W +: LEN_W]
//   retrig     in   [CH] per-channel retrigger mode
//   pulse_out  out  [CH] pulses
//   busy       out  [CH] high in ACTIVE or HOLDOFF
//   done       out  [CH] single-cycle end-of-pulse strobes
module oneshot_multi
  import oneshot_multi_pkg::*;
#(
  parameter int unsigned CH      = 4,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [CH-1:0]       trig_in,
  input  logic [CH*LEN_W-1:0] len,
  input  logic [CH-1:0]       retrig,
  output logic [CH-1:0]       pulse_out,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       done
);

  for (genvar g = 0; g < CH; g++) begin : g_chan
    oneshot_chan #(
      .LEN_W  (LEN_W),
      .HOLDOFF(HOLDOFF)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .trig_in  (trig_in[g]),
      .len      (len[g*LEN_W +: LEN_W]),
      .retrig   (retrig[g]),
      .pulse_out(pulse_out[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

endmodule
